// File: rtl/led_div_seq.sv
// Divider sequencer for the LED counter: produces div_o with a one-cycle wren_o load strobe,
// stepped by a debounced button (manual mode) or by a dwell timer that ping-pongs (sweep mode).
module led_div_seq #(
    parameter int DIVW         = 5,
    parameter int DIV_MIN      = 1,
    parameter int DIV_MAX      = 20,
    parameter int DIV_INIT     = 8,
    parameter int DEB_CYCLES   = 1000000,
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic            clk100,
    input  logic            rstn,
    input  logic            enable_i,
    input  logic            mode_i,
    input  logic            btn_i,
    output logic [DIVW-1:0] div_o,
    output logic            wren_o,
    output logic            dir_o
);

    localparam int DEBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int DWLW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DEBW-1:0] DEB_LAST = DEBW'(DEB_CYCLES - 1);
    localparam logic [DWLW-1:0] DWL_LAST = DWLW'(DWELL_CYCLES - 1);
    localparam logic [DIVW-1:0] MIN_V    = DIVW'(DIV_MIN);
    localparam logic [DIVW-1:0] MAX_V    = DIVW'(DIV_MAX);
    localparam logic [DIVW-1:0] INIT_V   = DIVW'(DIV_INIT);
    localparam logic [DIVW-1:0] MIN_P1_V = DIVW'(DIV_MIN + 1);
    localparam logic [DIVW-1:0] MAX_M1_V = DIVW'(DIV_MAX - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_deb;
    logic [DEBW-1:0] r_deb_cnt;
    logic [DWLW-1:0] r_dwell;
    logic            r_mode_q;
    logic            r_init_done;
    logic [DIVW-1:0] r_div;
    logic            r_wren;
    logic            r_dir;

    logic            w_press;
    logic            w_press_ok;
    logic            w_step;
    logic            w_dir_eff;
    logic [DIVW-1:0] w_div_nxt;
    logic            w_dir_nxt;
    logic            w_wren_nxt;
    logic [DWLW-1:0] w_dwell_nxt;

    function automatic logic in_range(input logic [DIVW-1:0] v);
        return (v >= MIN_V) && (v <= MAX_V);
    endfunction

    // Button synchroniser and debouncer; debounced level only moves after DEB_CYCLES stable samples.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb     <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_deb) begin
                if (r_deb_cnt == DEB_LAST) begin
                    r_deb     <= r_sync2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DEBW'(1);
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // A press is the cycle in which the debounced level is about to rise.
    assign w_press    = (r_sync2 != r_deb) && (r_deb_cnt == DEB_LAST) && r_sync2;
    // Blocking events right after a load keeps wren_o from ever firing two cycles in a row.
    assign w_press_ok = w_press && enable_i && r_init_done && !r_wren;
    assign w_step     = r_init_done && enable_i && mode_i && (mode_i == r_mode_q) &&
                        (r_dwell == DWL_LAST) && !r_wren;
    assign w_dir_eff  = r_dir ^ w_press_ok;

    // Next-state logic for divider, direction, strobe and dwell timer.
    always_comb begin
        w_div_nxt   = r_div;
        w_dir_nxt   = r_dir;
        w_wren_nxt  = 1'b0;
        w_dwell_nxt = r_dwell;
        if (!r_init_done) begin
            w_div_nxt   = INIT_V;
            w_wren_nxt  = 1'b1;
            w_dwell_nxt = '0;
        end else begin
            if ((mode_i != r_mode_q) || (enable_i && !mode_i)) begin
                w_dwell_nxt = '0;
            end else if (enable_i) begin
                w_dwell_nxt = (r_dwell == DWL_LAST) ? '0 : r_dwell + DWLW'(1);
            end else begin
                w_dwell_nxt = r_dwell;
            end

            if (!mode_i) begin
                if (w_press_ok) begin
                    w_wren_nxt = 1'b1;
                    w_div_nxt  = (!in_range(r_div) || (r_div == MAX_V)) ? MIN_V : r_div + DIVW'(1);
                end else begin
                    w_div_nxt = r_div;
                end
            end else begin
                w_dir_nxt = w_dir_eff;
                if (w_step) begin
                    w_wren_nxt = 1'b1;
                    if (!in_range(r_div)) begin
                        w_div_nxt = MIN_V;
                    end else if (w_dir_eff) begin
                        if (r_div == MAX_V) begin
                            w_dir_nxt = 1'b0;
                            w_div_nxt = MAX_M1_V;
                        end else begin
                            w_div_nxt = r_div + DIVW'(1);
                        end
                    end else begin
                        if (r_div == MIN_V) begin
                            w_dir_nxt = 1'b1;
                            w_div_nxt = MIN_P1_V;
                        end else begin
                            w_div_nxt = r_div - DIVW'(1);
                        end
                    end
                end else begin
                    w_div_nxt = r_div;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            r_div       <= INIT_V;
            r_wren      <= 1'b0;
            r_dir       <= 1'b1;
            r_dwell     <= '0;
            r_mode_q    <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_div       <= w_div_nxt;
            r_wren      <= w_wren_nxt;
            r_dir       <= w_dir_nxt;
            r_dwell     <= w_dwell_nxt;
            r_mode_q    <= mode_i;
            r_init_done <= 1'b1;
        end
    end

    assign div_o  = r_div;
    assign wren_o = r_wren;
    assign dir_o  = r_dir;

endmodule

// File: tb/tb_led_div_seq.sv
// Directed bench for led_div_seq with small parameters (DIV 2..5, init 3, debounce 4, dwell 8).
module tb_led_div_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enable;
    logic       mode;
    logic       btn;
    logic [4:0] div;
    logic       wren;
    logic       dir;

    int n_checks = 0;
    int n_err    = 0;
    int consec   = 0;
    logic prev_wren = 1'b0;

    typedef struct {
        logic [4:0] div;
        logic       dir;
    } step_t;

    step_t sweep_tbl[8];
    int    man_tbl[3];

    led_div_seq #(
        .DIVW(5), .DIV_MIN(2), .DIV_MAX(5), .DIV_INIT(3),
        .DEB_CYCLES(4), .DWELL_CYCLES(8)
    ) dut (
        .clk100  (clk),
        .rstn    (rstn),
        .enable_i(enable),
        .mode_i  (mode),
        .btn_i   (btn),
        .div_o   (div),
        .wren_o  (wren),
        .dir_o   (dir)
    );

    always #5 clk = ~clk;

    // Count back-to-back strobes over the whole run.
    always @(negedge clk) begin
        if (rstn && wren && prev_wren) consec <= consec + 1;
        prev_wren <= wren;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until wren is seen; k = -1 if the budget runs out.
    task automatic wait_wren(input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (wren) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic en, input logic md);
        rstn   = 1'b0;
        enable = en;
        mode   = md;
        btn    = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
    endtask

    initial begin
        int k;
        int cnt;
        int first;

        man_tbl[0] = 4; man_tbl[1] = 5; man_tbl[2] = 2;
        sweep_tbl[0] = '{5'd4, 1'b1};
        sweep_tbl[1] = '{5'd5, 1'b1};
        sweep_tbl[2] = '{5'd4, 1'b0};
        sweep_tbl[3] = '{5'd3, 1'b0};
        sweep_tbl[4] = '{5'd2, 1'b0};
        sweep_tbl[5] = '{5'd3, 1'b1};
        sweep_tbl[6] = '{5'd4, 1'b1};
        sweep_tbl[7] = '{5'd5, 1'b1};

        // Reset values, init load with enable low, then silence.
        rstn = 1'b0; enable = 1'b0; mode = 1'b0; btn = 1'b0;
        #23;
        chk("rst_div", div, 3);
        chk("rst_wren", wren, 0);
        chk("rst_dir", dir, 1);
        tick();
        rstn = 1'b1;
        tick();
        chk("init_wren", wren, 1);
        chk("init_div", div, 3);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (wren) cnt++;
        end
        chk("idle_wren_count", cnt, 0);

        // Manual mode: three clean presses.
        enable = 1'b1;
        mode   = 1'b0;
        tick();
        for (int p = 0; p < 3; p++) begin
            btn   = 1'b1;
            cnt   = 0;
            first = -1;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (wren) begin
                    cnt++;
                    if (first < 0) first = i;
                end
                if (i == 10) btn = 1'b0;
            end
            chk("man_latency", first, 6);
            chk("man_pulses", cnt, 1);
            chk("man_div", div, man_tbl[p]);
        end

        // Bouncy button never settles long enough.
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) btn = ~btn;
            tick();
            if (wren) cnt++;
        end
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wren) cnt++;
        end
        chk("bounce_wren", cnt, 0);
        chk("bounce_div", div, 2);

        // Sweep ping-pong from 3, direction up.
        do_reset(1'b1, 1'b1);
        tick();
        chk("sweep_init_wren", wren, 1);
        for (int s = 0; s < 8; s++) begin
            wait_wren(20, k);
            chk("sweep_period", k, 8);
            chk("sweep_div", div, sweep_tbl[s].div);
            chk("sweep_dir", dir, sweep_tbl[s].dir);
        end

        // Press lands in the same cycle as a dwell step at div 4 going up.
        do_reset(1'b1, 1'b1);
        tick();
        wait_wren(20, k);
        chk("coinc_pre_div", div, 4);
        chk("coinc_pre_dir", dir, 1);
        tick();
        tick();
        btn = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (wren) cnt++;
        end
        chk("coinc_wren", wren, 1);
        chk("coinc_div", div, 3);
        chk("coinc_dir", dir, 0);
        chk("coinc_pulses", cnt, 1);
        btn = 1'b0;
        repeat (12) tick();

        // Async reset mid-sweep, at dwell count 5 after a step.
        do_reset(1'b1, 1'b1);
        tick();
        wait_wren(20, k);
        chk("mid_pre_div", div, 4);
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        chk("mid_rst_div", div, 3);
        chk("mid_rst_wren", wren, 0);
        chk("mid_rst_dir", dir, 1);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("mid_init_wren", wren, 1);
        chk("mid_init_div", div, 3);
        wait_wren(20, k);
        chk("mid_first_step", k, 8);
        chk("mid_step_div", div, 4);

        tick();
        chk("no_consecutive_wren", consec, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
